// File: rtl/wb_stream_pkg.sv
// Shared definitions for the Wishbone stream arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE / OWN / ABORT)
//   CLASSIC, INCR, EOB : Wishbone cycle-type-identifier (cti) tags
//   idx_width() : bit width needed to index n items (minimum 1)
package wb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR    = 3'b010;
  localparam logic [2:0] EOB     = 3'b111;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_stream_rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector, one bit per port
//   last  : index of the previous owner; search starts at last+1
//   grant : one-hot winner (all zeros when nothing requests)
//   idx   : binary index of the winner (0 when nothing requests)
module wb_stream_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IW        = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IW-1:0]        idx
);

  int   cand;
  logic found;

  // NOTE: every output of this always_comb gets a default before the loop;
  // a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Walk last+1, last+2, ... wrapping; last itself is checked last.
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(last) + i) % NUM_PORTS;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_stream_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between NUM_PORTS
// streaming masters. A grant is held for a whole cycle (cyc high to cyc low)
// so bursts are never split. A watchdog ends a strobe that waits TIMEOUT
// cycles without ack/err/rty by pulsing err to the owner (TIMEOUT=0 disables).
//   m_*_i   : per-port master requests, packed, port 0 in the LSBs
//   m_*_o   : per-port terminations and shared read data
//   s_*_o   : shared bus towards the slave; all zero while idle
//   s_*_i   : slave responses
//   grant_o : one-hot current owner, zero when idle
module wb_stream_arbiter
  import wb_stream_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int WB_AW     = 32,
  parameter int WB_DW     = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*WB_AW-1:0]  m_adr_i,
  input  logic [NUM_PORTS*WB_DW-1:0]  m_dat_i,
  input  logic [NUM_PORTS*WB_DW/8-1:0] m_sel_i,
  input  logic [NUM_PORTS-1:0]        m_we_i,
  input  logic [NUM_PORTS-1:0]        m_cyc_i,
  input  logic [NUM_PORTS-1:0]        m_stb_i,
  input  logic [NUM_PORTS*3-1:0]      m_cti_i,
  input  logic [NUM_PORTS*2-1:0]      m_bte_i,
  output logic [WB_DW-1:0]            m_dat_o,
  output logic [NUM_PORTS-1:0]        m_ack_o,
  output logic [NUM_PORTS-1:0]        m_err_o,
  output logic [NUM_PORTS-1:0]        m_rty_o,
  output logic [WB_AW-1:0]            s_adr_o,
  output logic [WB_DW-1:0]            s_dat_o,
  output logic [WB_DW/8-1:0]          s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [WB_DW-1:0]            s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_PORTS-1:0]        grant_o
);

  localparam int IW = idx_width(NUM_PORTS);
  localparam int SW = WB_DW / 8;
  localparam int CW = idx_width(TIMEOUT);

  arb_state_e           state;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last;
  logic [CW-1:0]        wd_cnt;

  logic [NUM_PORTS-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 owner_cyc;
  logic                 bus_owned;
  logic                 slave_term;
  logic                 wd_expire;

  wb_stream_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_pick (
    .req   (m_cyc_i),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign owner_cyc  = m_cyc_i[owner];
  assign bus_owned  = (state != IDLE);
  assign slave_term = s_ack_i | s_err_i | s_rty_i;
  // A slave termination in the expiry cycle wins over the watchdog.
  assign wd_expire  = (TIMEOUT != 0) && (state == OWN) && s_stb_o && !slave_term &&
                      (int'(wd_cnt) == TIMEOUT - 1);

  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

  // Shared bus mux: owner's fields while owned, zeros while idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (bus_owned) begin
      s_adr_o = m_adr_i[int'(owner)*WB_AW +: WB_AW];
      s_dat_o = m_dat_i[int'(owner)*WB_DW +: WB_DW];
      s_sel_o = m_sel_i[int'(owner)*SW +: SW];
      s_we_o  = m_we_i[owner];
      s_cyc_o = owner_cyc;
      s_stb_o = (state == OWN) && m_stb_i[owner];
      s_cti_o = m_cti_i[int'(owner)*3 +: 3];
      s_bte_o = m_bte_i[int'(owner)*2 +: 2];
    end
  end

  // Terminations reach only the owner; ABORT substitutes a one-cycle err.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state == OWN) begin
      m_ack_o = grant_q & {NUM_PORTS{s_ack_i}};
      m_err_o = grant_q & {NUM_PORTS{s_err_i}};
      m_rty_o = grant_q & {NUM_PORTS{s_rty_i}};
    end else if (state == ABORT) begin
      m_err_o = grant_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      owner   <= '0;
      last    <= IW'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|m_cyc_i) begin
            state   <= OWN;
            grant_q <= pick_grant;
            owner   <= pick_idx;
          end
        end
        OWN: begin
          if (!owner_cyc) begin
            state   <= IDLE;
            grant_q <= '0;
            last    <= owner;
          end else if (wd_expire) begin
            state <= ABORT;
          end
        end
        ABORT:   state <= OWN;
        default: state <= IDLE;
      endcase
    end
  end

  // Watchdog: counts consecutive strobe cycles without a termination.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != OWN || !s_stb_o || slave_term || wd_expire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_stream_arbiter.sv
// Directed self-checking bench for wb_stream_arbiter (2 ports, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 time unit later, well away from the next edge.
module tb_wb_stream_arbiter;
  import wb_stream_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*AW-1:0]  m_adr_i;
  logic [NP*DW-1:0]  m_dat_i;
  logic [NP*DW/8-1:0] m_sel_i;
  logic [NP-1:0]     m_we_i, m_cyc_i, m_stb_i;
  logic [NP*3-1:0]   m_cti_i;
  logic [NP*2-1:0]   m_bte_i;
  logic [DW-1:0]     m_dat_o;
  logic [NP-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [NP-1:0]     grant_o;

  int checks = 0;
  int errors = 0;

  wb_stream_arbiter #(
    .NUM_PORTS (NP),
    .WB_AW     (AW),
    .WB_DW     (DW),
    .TIMEOUT   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_we_i  (m_we_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_cti_i (m_cti_i),
    .m_bte_i (m_bte_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_cti_o (s_cti_o),
    .s_bte_o (s_bte_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i),
    .grant_o (grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Write data is derived from the address so the data mux can be checked.
  task automatic set_port(input int p, input logic cyc, input logic stb,
                          input logic [31:0] adr, input logic [2:0] cti);
    m_cyc_i[p]            = cyc;
    m_stb_i[p]            = stb;
    m_we_i[p]             = 1'b1;
    m_adr_i[p*AW +: AW]   = adr;
    m_dat_i[p*DW +: DW]   = adr ^ 32'hA5A5_0000;
    m_sel_i[p*4 +: 4]     = 4'hF;
    m_cti_i[p*3 +: 3]     = cti;
    m_bte_i[p*2 +: 2]     = 2'b00;
  endtask

  task automatic clear_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    // Fields present but cyc low: the shared bus must still read zero.
    set_port(0, 1'b0, 1'b0, 32'h0000_1234, INCR);
    tick();
    tick();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b want 00", s_cyc_o, s_stb_o); end
    checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 6'b0) begin errors++; $display("FAIL reset_terms: got %b want 000000", {m_ack_o, m_err_o, m_rty_o}); end
    checks++; if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0) begin errors++; $display("FAIL reset_idle_bus: got adr %h dat %h want 0", s_adr_o, s_dat_o); end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_burst();
    int acks;
    logic adr_ok;
    acks   = 0;
    adr_ok = 1'b1;
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h0000_1000, INCR);
    settle();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL burst_grant_latency: got %b want 00", grant_o); end
    tick();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL burst_grant: got %b want 01", grant_o); end
    for (int b = 0; b < 4; b++) begin
      set_port(0, 1'b1, 1'b1, 32'h0000_1000 + 32'(4 * b), (b == 3) ? EOB : INCR);
      s_ack_i = 1'b1;
      settle();
      if (s_adr_o !== 32'h0000_1000 + 32'(4 * b)) adr_ok = 1'b0;
      if (m_ack_o === 2'b01) acks++;
      tick();
    end
    checks++; if (!adr_ok) begin errors++; $display("FAIL burst_addr: got mismatched s_adr_o want 1000..100c"); end
    checks++; if (acks !== 4) begin errors++; $display("FAIL burst_acks: got %0d want 4", acks); end
    set_port(0, 1'b0, 1'b0, 32'h0, CLASSIC);
    s_ack_i = 1'b0;
    settle();
    checks++; if (s_cyc_o !== 1'b0 || m_ack_o !== 2'b00) begin errors++; $display("FAIL burst_drop: got cyc %b ack %b want 0 00", s_cyc_o, m_ack_o); end
    tick();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL burst_release: got %b want 00", grant_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h0000_4000, CLASSIC);
    set_port(1, 1'b1, 1'b1, 32'h0000_5000, CLASSIC);
    tick();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_first: got %b want 01", grant_o); end
    s_ack_i = 1'b1;
    settle();
    checks++; if (m_ack_o !== 2'b01) begin errors++; $display("FAIL rr_ack0: got %b want 01", m_ack_o); end
    tick();
    set_port(0, 1'b0, 1'b0, 32'h0, CLASSIC);
    s_ack_i = 1'b0;
    tick();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b want 00", grant_o); end
    set_port(0, 1'b1, 1'b1, 32'h0000_4000, CLASSIC);
    tick();
    checks++; if (grant_o !== 2'b10 || s_adr_o !== 32'h0000_5000) begin errors++; $display("FAIL rr_second: got %b adr %h want 10 00005000", grant_o, s_adr_o); end
    s_ack_i = 1'b1;
    settle();
    checks++; if (m_ack_o !== 2'b10) begin errors++; $display("FAIL rr_ack1: got %b want 10", m_ack_o); end
    tick();
    set_port(1, 1'b0, 1'b0, 32'h0, CLASSIC);
    s_ack_i = 1'b0;
    tick();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_gap2: got %b want 00", grant_o); end
    tick();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_third: got %b want 01", grant_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_mid_burst();
    logic held;
    held = 1'b1;
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h0000_2000, INCR);
    tick();
    for (int b = 0; b < 3; b++) begin
      set_port(0, 1'b1, 1'b1, 32'h0000_2000 + 32'(4 * b), (b == 2) ? EOB : INCR);
      s_ack_i = 1'b1;
      settle();
      if (s_adr_o !== 32'h0000_2000 + 32'(4 * b) || m_ack_o !== 2'b01 || grant_o !== 2'b01) held = 1'b0;
      tick();
      if (b == 0) set_port(1, 1'b1, 1'b1, 32'h0000_9000, CLASSIC);
    end
    checks++; if (!held) begin errors++; $display("FAIL mid_burst_hold: got bus moved or port1 acked want port0 contiguous"); end
    set_port(0, 1'b0, 1'b0, 32'h0, CLASSIC);
    s_ack_i = 1'b0;
    tick();
    checks++; if (grant_o !== 2'b00 || m_ack_o !== 2'b00) begin errors++; $display("FAIL mid_burst_gap: got %b ack %b want 00 00", grant_o, m_ack_o); end
    tick();
    checks++; if (grant_o !== 2'b10 || s_adr_o !== 32'h0000_9000) begin errors++; $display("FAIL mid_burst_next: got %b adr %h want 10 00009000", grant_o, s_adr_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    logic stb_ok;
    logic err_early;
    stb_ok    = 1'b1;
    err_early = 1'b0;
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h0000_3000, CLASSIC);
    tick();
    // Sixteen unanswered strobe cycles, then the abort cycle.
    for (int k = 1; k <= 16; k++) begin
      settle();
      if (s_stb_o !== 1'b1) stb_ok = 1'b0;
      if (m_err_o !== 2'b00) err_early = 1'b1;
      tick();
    end
    checks++; if (!stb_ok || err_early) begin errors++; $display("FAIL wd_wait: got stb_ok %b early_err %b want 1 0", stb_ok, err_early); end
    checks++; if (s_stb_o !== 1'b0 || m_err_o !== 2'b01 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL wd_abort: got stb %b err %b cyc %b want 0 01 1", s_stb_o, m_err_o, s_cyc_o); end
    set_port(0, 1'b0, 1'b0, 32'h0, CLASSIC);
    tick();
    checks++; if (m_err_o !== 2'b00) begin errors++; $display("FAIL wd_err_pulse: got %b want 00", m_err_o); end
    tick();
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL wd_release: got %b want 00", grant_o); end

    // Ack arriving exactly in the expiry cycle wins.
    set_port(0, 1'b1, 1'b1, 32'h0000_3100, CLASSIC);
    tick();
    for (int k = 1; k <= 15; k++) tick();
    s_ack_i = 1'b1;
    settle();
    checks++; if (m_ack_o !== 2'b01 || m_err_o !== 2'b00) begin errors++; $display("FAIL wd_ack_wins: got ack %b err %b want 01 00", m_ack_o, m_err_o); end
    tick();
    s_ack_i = 1'b0;
    settle();
    checks++; if (s_stb_o !== 1'b1 || m_err_o !== 2'b00) begin errors++; $display("FAIL wd_no_abort: got stb %b err %b want 1 00", s_stb_o, m_err_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_port(0, 1'b1, 1'b1, 32'h0000_6000, INCR);
    tick();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rstmid_grant: got %b want 01", grant_o); end
    s_ack_i = 1'b1;
    rst_n   = 1'b0;
    tick();
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00 || m_ack_o !== 2'b00) begin errors++; $display("FAIL rstmid_abort: got cyc %b stb %b grant %b ack %b want 0 0 00 00", s_cyc_o, s_stb_o, grant_o, m_ack_o); end
    rst_n   = 1'b1;
    s_ack_i = 1'b0;
    set_port(1, 1'b1, 1'b1, 32'h0000_7000, CLASSIC);
    tick();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rstmid_first: got %b want 01", grant_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_err_rty();
    do_reset();
    set_port(1, 1'b1, 1'b1, 32'h0000_9000, CLASSIC);
    s_dat_i = 32'hDEAD_BEEF;
    tick();
    checks++; if (grant_o !== 2'b10 || s_dat_o !== 32'hA5A5_9000 || s_we_o !== 1'b1) begin errors++; $display("FAIL errrty_mux: got %b dat %h we %b want 10 a5a59000 1", grant_o, s_dat_o, s_we_o); end
    checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL errrty_rdata: got %h want deadbeef", m_dat_o); end
    s_err_i = 1'b1;
    settle();
    checks++; if (m_err_o !== 2'b10 || m_ack_o !== 2'b00 || m_rty_o !== 2'b00) begin errors++; $display("FAIL errrty_err: got err %b ack %b rty %b want 10 00 00", m_err_o, m_ack_o, m_rty_o); end
    s_err_i = 1'b0;
    s_rty_i = 1'b1;
    settle();
    checks++; if (m_rty_o !== 2'b10 || m_err_o !== 2'b00) begin errors++; $display("FAIL errrty_rty: got rty %b err %b want 10 00", m_rty_o, m_err_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_burst();
    test_round_robin();
    test_mid_burst();
    test_watchdog();
    test_reset_mid();
    test_err_rty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
